// File: rtl/rom_streamer.sv
// rom_streamer: burst read master for a 1-cycle-latency synchronous ROM, streaming words out on valid/ready.
// Optional ROM_STREAMER_LAST_EN adds an m_last output marking the final beat of each burst.
`timescale 1ns/1ps

module rom_streamer_chk (
  input logic       i_clk,
  input logic       i_rst,
  input logic       i_push,
  input logic       i_pop,
  input logic [1:0] i_occ,
  input logic       i_issue,
  input logic       i_inflight
);

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_push && !i_pop && (i_occ == 2'd2)));

  a_pending_bound: assert property (@(posedge i_clk) disable iff (i_rst)
    ({1'b0, i_occ} + {2'b00, i_inflight}) <= 3'd2);

  a_no_issue_when_full: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_issue && (i_occ == 2'd2) && i_inflight && !i_pop));

endmodule

module rom_streamer #(
  parameter int size  = 2048,
  parameter int width = 16,
  parameter int asize = $clog2(size)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [asize-1:0] base_addr,
  input  logic [asize:0]   len,
  output logic             busy,
  output logic             done,
  output logic             rom_en,
  output logic [asize-1:0] rom_addr,
  input  logic [width-1:0] rom_dout,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [width-1:0] m_data
`ifdef ROM_STREAMER_LAST_EN
  , output logic           m_last
`endif
);

  localparam logic [asize-1:0] LAST_ADDR = asize'(size - 1);
  localparam logic [asize-1:0] ZERO_ADDR = {asize{1'b0}};
  localparam logic [asize:0]   ZERO_CNT  = {(asize + 1){1'b0}};
  localparam logic [asize:0]   ONE_CNT   = {{asize{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [asize:0]   r_len;
  logic [asize:0]   r_issued;
  logic [asize:0]   r_accepted;
  logic [asize-1:0] r_addr;
  logic             r_inflight;

  logic [width-1:0] r_buf [2];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_occ;

  logic             w_push;
  logic             w_pop;
  logic [2:0]       w_pending;
  logic             w_room;
  logic             w_issue;
  logic             w_last_issue;
  logic             w_head_last;
  logic             w_last_accept;
  logic             w_accept_start;

  // Issue/acceptance decisions; a pop this cycle frees a slot for a read issued this cycle.
  always_comb begin
    w_accept_start = (r_state == S_IDLE) && start;
    w_push         = r_inflight;
    w_pop          = (r_occ != 2'd0) && m_ready;
    w_pending      = {1'b0, r_occ} + {2'b00, r_inflight};
    if (w_pop) begin
      w_room = (w_pending <= 3'd2);
    end else begin
      w_room = (w_pending < 3'd2);
    end
    w_issue       = (r_state == S_FETCH) && (r_issued < r_len) && w_room;
    w_last_issue  = w_issue && ((r_issued + ONE_CNT) == r_len);
    w_head_last   = (r_occ != 2'd0) && ((r_accepted + ONE_CNT) == r_len);
    w_last_accept = w_pop && w_head_last;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (len == ZERO_CNT) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_FETCH;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FETCH: begin
        if (w_last_issue) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (w_last_accept) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state; rom_en is the live issue decision.
  always_comb begin
    busy     = (r_state != S_IDLE);
    done     = (r_state == S_DONE);
    rom_en   = w_issue;
    rom_addr = r_addr;
    m_valid  = (r_occ != 2'd0);
    m_data   = r_buf[r_rd_ptr];
`ifdef ROM_STREAMER_LAST_EN
    m_last   = w_head_last;
`endif
  end

  // Burst bookkeeping: length, issue/accept counts and the wrapping read address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len      <= ZERO_CNT;
      r_issued   <= ZERO_CNT;
      r_accepted <= ZERO_CNT;
      r_addr     <= ZERO_ADDR;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_accept_start) begin
        r_len      <= len;
        r_issued   <= ZERO_CNT;
        r_accepted <= ZERO_CNT;
        r_addr     <= base_addr;
      end else begin
        if (w_issue) begin
          r_issued <= r_issued + ONE_CNT;
          if (r_addr == LAST_ADDR) begin
            r_addr <= ZERO_ADDR;
          end else begin
            r_addr <= r_addr + {{(asize - 1){1'b0}}, 1'b1};
          end
        end
        if (w_pop) begin
          r_accepted <= r_accepted + ONE_CNT;
        end
      end
    end
  end

  // Two-entry return buffer; push and pop in the same cycle keep occupancy and order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf[0] <= {width{1'b0}};
      r_buf[1] <= {width{1'b0}};
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (w_push) begin
        r_buf[r_wr_ptr] <= rom_dout;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  rom_streamer_chk u_chk (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_occ      (r_occ),
    .i_issue    (w_issue),
    .i_inflight (r_inflight)
  );

endmodule

// File: tb/tb_rom_streamer.sv
// Bench for rom_streamer: table of bursts plus reset/start-while-busy sequences, scoreboarded against a ROM image.
`timescale 1ns/1ps

module tb_rom_streamer;

  localparam int SIZE  = 2048;
  localparam int WIDTH = 16;
  localparam int ASIZE = 11;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [ASIZE-1:0] base_addr;
  logic [ASIZE:0]   len;
  logic             busy;
  logic             done;
  logic             rom_en;
  logic [ASIZE-1:0] rom_addr;
  logic [WIDTH-1:0] rom_dout;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
`ifdef ROM_STREAMER_LAST_EN
  logic             m_last;
`endif

  always #5 clk = ~clk;

  rom_streamer #(.size(SIZE), .width(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_dout  (rom_dout),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data)
`ifdef ROM_STREAMER_LAST_EN
    , .m_last  (m_last)
`endif
  );

  logic [WIDTH-1:0] rom_mem [SIZE];

  function automatic logic [15:0] word_at(input logic [10:0] a);
    return 16'h9FF0 + {5'd0, a};
  endfunction

  initial begin
    for (int i = 0; i < SIZE; i++) rom_mem[i] = word_at(i[10:0]);
  end

  always @(posedge clk) begin
    if (rom_en) rom_dout <= rom_mem[rom_addr];
  end

  typedef struct {
    logic [10:0] base;
    logic [11:0] blen;
    logic [31:0] mask;
    int          exp_done;
    int          inj;
  } vec_t;

  vec_t        vecs [9];
  int          checks;
  int          failures;
  int          cyc;
  logic [31:0] cur_mask;
  logic [15:0] q [$];
  logic [10:0] exp_addr;
  int          n_en, n_beats, n_issued, n_acc;
  logic        stall_prev;
  logic [15:0] prev_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic ready_at(input int c);
    if (c < 32) return cur_mask[c];
    return 1'b1;
  endfunction

  task automatic monitor();
    logic pop;
    pop = m_valid && m_ready;
    if (busy) check("outstanding_le_2", 32'(n_issued - n_acc <= 2), 32'd1);
    if (rom_en) begin
      check("rom_addr", 32'(rom_addr), 32'(exp_addr));
      exp_addr = exp_addr + 11'd1;
      n_en++;
    end
    if (stall_prev) begin
      check("stall_valid", 32'(m_valid), 32'd1);
      check("stall_data", 32'(m_data), 32'(prev_data));
    end
    if (m_valid) begin
      check("valid_with_pending", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
`ifdef ROM_STREAMER_LAST_EN
        check("m_last", 32'(m_last), 32'(q.size() == 1));
`endif
        if (m_ready) begin
          check("m_data", 32'(m_data), 32'(q.pop_front()));
          n_beats++;
        end
      end
    end else begin
`ifdef ROM_STREAMER_LAST_EN
      check("m_last_idle", 32'(m_last), 32'd0);
`endif
    end
    n_issued  += int'(rom_en);
    n_acc     += int'(pop);
    stall_prev = m_valid && !m_ready;
    prev_data  = m_data;
  endtask

  task automatic step(input logic st, input logic [10:0] b, input logic [11:0] l);
    @(posedge clk);
    #1;
    cyc++;
    start     = st;
    base_addr = b;
    len       = l;
    m_ready   = ready_at(cyc);
    @(negedge clk);
    monitor();
  endtask

  task automatic launch(input vec_t v);
    logic [10:0] a;
    cur_mask = v.mask;
    n_en = 0; n_beats = 0; n_issued = 0; n_acc = 0;
    exp_addr = v.base;
    a = v.base;
    for (int i = 0; i < int'(v.blen); i++) begin
      q.push_back(word_at(a));
      a = a + 11'd1;
    end
    @(posedge clk);
    #1;
    cyc       = 0;
    start     = 1'b1;
    base_addr = v.base;
    len       = v.blen;
    m_ready   = ready_at(0);
    @(negedge clk);
    monitor();
  endtask

  task automatic run_vec(input vec_t v);
    int got_done;
    int budget;
    got_done = -1;
    budget   = int'(v.blen) * 4 + 20;
    launch(v);
    for (int k = 0; k < budget; k++) begin
      step(cyc + 1 == v.inj, 11'h200, 12'd3);
      if (cyc == 1) check("busy_cycle1", 32'(busy), 32'd1);
      if (done) begin
        got_done = cyc;
        break;
      end
    end
    check("done_seen", 32'(got_done >= 0), 32'd1);
    if (v.exp_done >= 0) check("done_cycle", got_done, v.exp_done);
    step(1'b0, 11'd0, 12'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    check("done_one_cycle", 32'(done), 32'd0);
    check("rom_en_count", n_en, 32'(v.blen));
    check("beats", n_beats, 32'(v.blen));
    check("queue_empty", q.size(), 32'd0);
    q.delete();
  endtask

  initial begin
    vec_t rv;
    checks = 0; failures = 0; cyc = 0;
    stall_prev = 1'b0; prev_data = 16'd0;
    cur_mask = 32'hFFFF_FFFF;
    rst = 1'b1; start = 1'b0; base_addr = 11'd0; len = 12'd0; m_ready = 1'b0;

    vecs[0] = '{11'h010, 12'd4,    32'hFFFF_FFFF, 7,    0};
    vecs[1] = '{11'h7FE, 12'd4,    32'hFFFF_FFFF, 7,    0};
    vecs[2] = '{11'h020, 12'd8,    32'h9999_9999, -1,   0};
    vecs[3] = '{11'h100, 12'd0,    32'hFFFF_FFFF, 1,    0};
    vecs[4] = '{11'h7FF, 12'd1,    32'hFFFF_FFFF, 4,    0};
    vecs[5] = '{11'h030, 12'd6,    32'hFFFF_FFFF, 9,    2};
    vecs[6] = '{11'h070, 12'd3,    32'hFFFF_FF9F, 8,    0};
    vecs[7] = '{11'h400, 12'd2048, 32'hFFFF_FFFF, 2051, 0};
    vecs[8] = '{11'h055, 12'd5,    32'h5555_5555, -1,   0};

    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rom_en", 32'(rom_en), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
`ifdef ROM_STREAMER_LAST_EN
    check("rst_m_last", 32'(m_last), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Reset in the middle of a burst, after three beats have been transferred.
    rv = '{11'h040, 12'd8, 32'hFFFF_FFFF, -1, 0};
    launch(rv);
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 11'd0, 12'd0);
      if (n_beats == 3) break;
    end
    check("beats_before_reset", n_beats, 32'd3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_m_valid", 32'(m_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rom_en", 32'(rom_en), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_m_data", 32'(m_data), 32'd0);
    q.delete();
    stall_prev = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 11'd0, 12'd0);
      check("rst_hold_done", 32'(done), 32'd0);
    end
    rst = 1'b0;
    step(1'b0, 11'd0, 12'd0);
    check("post_rst_idle_valid", 32'(m_valid), 32'd0);
    rv = '{11'h060, 12'd3, 32'hFFFF_FFFF, 6, 0};
    run_vec(rv);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
